// File: rtl/cmd_frame_pkg.sv
// Shared encodings for the UART command frame encoder: request kinds, opcodes,
// frame lengths and FSM states.
package cmd_frame_pkg;

  localparam int MAX_FRAME_LEN = 6;

  // Opcode bytes mirror the CMD_* values of the serial-out command decoder.
  localparam logic [7:0] CMD_FREQ   = 8'hA1;
  localparam logic [7:0] CMD_PERIOD = 8'hA2;
  localparam logic [7:0] CMD_DATA   = 8'hA3;
  localparam logic [7:0] CMD_CTRL   = 8'hA4;
  localparam logic [7:0] CMD_REPEAT = 8'hA5;
  localparam logic [7:0] CMD_GLOBAL = 8'hA6;

  typedef enum logic [2:0] {
    KIND_FREQ   = 3'd0,
    KIND_PERIOD = 3'd1,
    KIND_DATA   = 3'd2,
    KIND_CTRL   = 3'd3,
    KIND_REPEAT = 3'd4,
    KIND_GLOBAL = 3'd5
  } req_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [MAX_FRAME_LEN-1:0][7:0] frame_t;

  // Zero length marks an unsupported kind.
  function automatic logic [2:0] frame_len(input logic [2:0] kind);
    case (kind)
      KIND_FREQ:   frame_len = 3'd5;
      KIND_PERIOD: frame_len = 3'd3;
      KIND_DATA:   frame_len = 3'd6;
      KIND_CTRL:   frame_len = 3'd3;
      KIND_REPEAT: frame_len = 3'd3;
      KIND_GLOBAL: frame_len = 3'd2;
      default:     frame_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_frame_pack.sv
// Combinational packer: request kind/channel/payload to byte array, length and
// invalid flag. Multi-byte fields go out LSB first.
module cmd_frame_pack
  import cmd_frame_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [7:0]  chan_i,
  input  logic [31:0] payload_i,
  output frame_t      bytes_o,
  output logic [2:0]  len_o,
  output logic        invalid_o
);

  always_comb begin
    bytes_o = '0;
    case (kind_i)
      KIND_FREQ: begin
        bytes_o[0] = CMD_FREQ;
        bytes_o[1] = payload_i[7:0];
        bytes_o[2] = payload_i[15:8];
        bytes_o[3] = payload_i[23:16];
        bytes_o[4] = payload_i[31:24];
      end
      KIND_PERIOD: begin
        bytes_o[0] = CMD_PERIOD;
        bytes_o[1] = payload_i[7:0];
        bytes_o[2] = payload_i[15:8];
      end
      KIND_DATA: begin
        bytes_o[0] = CMD_DATA;
        bytes_o[1] = chan_i;
        bytes_o[2] = payload_i[7:0];
        bytes_o[3] = payload_i[15:8];
        bytes_o[4] = payload_i[23:16];
        bytes_o[5] = payload_i[31:24];
      end
      KIND_CTRL: begin
        bytes_o[0] = CMD_CTRL;
        bytes_o[1] = chan_i;
        bytes_o[2] = {4'h0, payload_i[3:0]};
      end
      KIND_REPEAT: begin
        bytes_o[0] = CMD_REPEAT;
        bytes_o[1] = chan_i;
        bytes_o[2] = payload_i[7:0];
      end
      KIND_GLOBAL: begin
        bytes_o[0] = CMD_GLOBAL;
        bytes_o[1] = {7'h0, payload_i[0]};
      end
      default: bytes_o = '0;
    endcase
  end

  assign len_o     = frame_len(kind_i);
  assign invalid_o = (len_o == 3'd0);

endmodule

// File: rtl/cmd_frame_tx.sv
// Command frame transmitter: latches one packed request and walks its bytes
// through the UART byte handshake with optional inter-byte gap and timeout.
module cmd_frame_tx
  import cmd_frame_pkg::*;
#(
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_kind_i,
  input  logic [7:0]  req_chan_i,
  input  logic [31:0] req_payload_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_done_tick_i,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        invalid_o
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  frame_t           buf_q;
  logic [2:0]       len_q, idx_q;
  logic [TMR_W-1:0] timer_q;
  logic [GAP_W-1:0] gap_q;
  logic             invalid_q;

  frame_t     pk_bytes;
  logic [2:0] pk_len;
  logic       pk_invalid;
  logic       accept, last_byte, timer_hit;

  cmd_frame_pack u_pack (
    .kind_i    (req_kind_i),
    .chan_i    (req_chan_i),
    .payload_i (req_payload_i),
    .bytes_o   (pk_bytes),
    .len_o     (pk_len),
    .invalid_o (pk_invalid)
  );

  // Ready is withheld while reset is asserted so nothing is accepted into a held FSM.
  assign req_ready_o  = (state_q == ST_IDLE) && !rst_n;
  assign accept       = req_valid_i && req_ready_o;
  assign busy_o       = (state_q != ST_IDLE);
  assign tx_start_o   = (state_q == ST_START);
  assign frame_done_o = (state_q == ST_DONE);
  assign invalid_o    = invalid_q;
  assign tx_data_o    = (state_q == ST_IDLE) ? 8'h00 : buf_q[idx_q];
  assign last_byte    = (idx_q == len_q - 3'd1);
  assign timer_hit    = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    timeout_o = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept && !pk_invalid) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A done tick in the expiry cycle still completes the byte.
        if (tx_done_tick_i) begin
          if (last_byte)           state_d = ST_DONE;
          else if (GAP_CYCLES > 0) state_d = ST_GAP;
          else                     state_d = ST_START;
        end else if (timer_hit) begin
          timeout_o = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_GAP:   if (gap_q == GAP_LAST) state_d = ST_START;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      idx_q     <= 3'd0;
      len_q     <= 3'd0;
      timer_q   <= '0;
      gap_q     <= '0;
      invalid_q <= 1'b0;
    end else begin
      invalid_q <= accept && pk_invalid;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx_q <= 3'd0;
            len_q <= pk_len;
          end
        end
        ST_START: timer_q <= '0;
        ST_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (tx_done_tick_i) begin
            idx_q <= idx_q + 3'd1;
            gap_q <= '0;
          end
        end
        ST_GAP:  gap_q <= gap_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Frame bytes are pure data; tx_data_o is gated to zero whenever idle.
  always_ff @(posedge clk_i) begin
    if (accept) buf_q <= pk_bytes;
  end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Scoreboard bench for cmd_frame_tx with a 3-cycle inter-byte gap and a
// 50-cycle byte timeout; a simple UART model answers each byte after a delay.
module tb_cmd_frame_tx;
  import cmd_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [7:0]  req_chan;
  logic [31:0] req_payload;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        frame_done;
  logic        busy;
  logic        timeout;
  logic        invalid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  cmd_frame_tx #(.GAP_CYCLES(3), .TIMEOUT_CYCLES(50)) u_dut (
    .clk_i          (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_kind_i     (req_kind),
    .req_chan_i     (req_chan),
    .req_payload_i  (req_payload),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .tx_done_tick_i (tx_done),
    .frame_done_o   (frame_done),
    .busy_o         (busy),
    .timeout_o      (timeout),
    .invalid_o      (invalid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected byte stream for one request, built from the protocol table.
  function automatic void push_frame(input logic [2:0] kind, input logic [7:0] chan,
                                     input logic [31:0] p);
    case (kind)
      3'd0: begin
        exp_q.push_back(CMD_FREQ);
        for (int i = 0; i < 4; i++) exp_q.push_back(p[8*i +: 8]);
      end
      3'd1: begin
        exp_q.push_back(CMD_PERIOD); exp_q.push_back(p[7:0]); exp_q.push_back(p[15:8]);
      end
      3'd2: begin
        exp_q.push_back(CMD_DATA); exp_q.push_back(chan);
        for (int i = 0; i < 4; i++) exp_q.push_back(p[8*i +: 8]);
      end
      3'd3: begin
        exp_q.push_back(CMD_CTRL); exp_q.push_back(chan); exp_q.push_back({4'h0, p[3:0]});
      end
      3'd4: begin
        exp_q.push_back(CMD_REPEAT); exp_q.push_back(chan); exp_q.push_back(p[7:0]);
      end
      3'd5: begin
        exp_q.push_back(CMD_GLOBAL); exp_q.push_back({7'h0, p[0]});
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_req(input logic [2:0] kind, input logic [7:0] chan, input logic [31:0] p);
    int waited = 0;
    req_kind = kind; req_chan = chan; req_payload = p; req_valid = 1'b1;
    while (!req_ready && waited < 200) begin
      @(negedge clk); waited++;
    end
    check_eq("req_ready_wait", 32'(waited < 200), 32'd1);
    push_frame(kind, chan, p);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic take_start(output logic [7:0] exp);
    check_eq("tx_start", 32'(tx_start), 32'd1);
    check_eq("ready_low", 32'(req_ready), 32'd0);
    check_eq("busy_high", 32'(busy), 32'd1);
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      exp = 8'h00;
    end else begin
      exp = exp_q.pop_front();
      check_eq("tx_data", 32'(tx_data), 32'(exp));
    end
  endtask

  // Starts in the START cycle of byte 0; answers each byte and checks gaps and frame_done.
  task automatic serve_frame(input int n, input int d_first);
    logic [7:0] exp;
    int d, k;
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        k = 1;
        while (!tx_start && k < 100) begin
          @(negedge clk); k++;
        end
        check_eq("done_to_start", 32'(k), 32'd4);
      end
      take_start(exp);
      d = (b == 0) ? d_first : 1 + (b % 3);
      repeat (d) @(negedge clk);
      check_eq("data_stable", 32'(tx_data), 32'(exp));
      tx_done = 1'b1;
      #1;
      check_eq("no_timeout", 32'(timeout), 32'd0);
      @(negedge clk);
      tx_done = 1'b0;
      if (b == n - 1) begin
        check_eq("frame_done", 32'(frame_done), 32'd1);
        @(negedge clk);
        check_eq("frame_done_pulse", 32'(frame_done), 32'd0);
        check_eq("ready_after_frame", 32'(req_ready), 32'd1);
      end
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int starts = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    check_eq(tag, 32'(starts), 32'd0);
  endtask

  initial begin
    logic [7:0] exp;
    rst_n = 1'b1; req_valid = 1'b0; req_kind = '0; req_chan = '0; req_payload = '0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_flags", 32'({frame_done, timeout, invalid}), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(req_ready), 32'd1);

    send_req(3'd0, 8'h00, 32'h5555_5555); serve_frame(5, 3);
    send_req(3'd1, 8'h00, 32'h0000_0514); serve_frame(3, 1);
    send_req(3'd3, 8'd13, 32'hABCD_0009); serve_frame(3, 2);
    send_req(3'd4, 8'h07, 32'h0000_002A); serve_frame(3, 4);
    send_req(3'd5, 8'h00, 32'hFFFF_FFFE); serve_frame(2, 1);
    // Done arrives in the very cycle the byte timer expires.
    send_req(3'd5, 8'h00, 32'h0000_0001); serve_frame(2, 50);
    send_req(3'd2, 8'h01, 32'h1234_5678); serve_frame(6, 2);
    send_req(3'd2, 8'h01, 32'h1234_5678); serve_frame(6, 1);

    send_req(3'd7, 8'h00, 32'h0000_0000);
    check_eq("invalid_pulse", 32'(invalid), 32'd1);
    check_eq("invalid_no_start", 32'(tx_start), 32'd0);
    @(negedge clk);
    check_eq("invalid_one_cycle", 32'(invalid), 32'd0);
    check_eq("invalid_ready", 32'(req_ready), 32'd1);
    expect_quiet("invalid_quiet", 6);

    send_req(3'd0, 8'h00, 32'hDEAD_BEEF);
    take_start(exp);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 49) check_eq("timeout_early", 32'(timeout), 32'd0);
      if (c == 50) check_eq("timeout_pulse", 32'(timeout), 32'd1);
    end
    @(negedge clk);
    check_eq("timeout_ready", 32'(req_ready), 32'd1);
    check_eq("timeout_one_cycle", 32'(timeout), 32'd0);
    exp_q.delete();
    expect_quiet("timeout_quiet", 8);

    send_req(3'd2, 8'h02, 32'hCAFE_F00D);
    take_start(exp);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_tx_start", 32'(tx_start), 32'd0);
    check_eq("midrst_tx_data", 32'(tx_data), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    expect_quiet("midrst_quiet", 8);
    check_eq("midrst_ready", 32'(req_ready), 32'd1);

    send_req(3'd4, 8'hC3, 32'h0000_0081); serve_frame(3, 2);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
